// File: rtl/pcs_64b66b_pkg.sv
// Shared constants and types for the 64b/66b transmit encoder: sync headers,
// block type bytes, 7-bit control codes, block classes and TX FSM states.
package pcs_64b66b_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam logic [7:0] BT_C  = 8'h1E;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'hAA;
  localparam logic [7:0] BT_T3 = 8'hB4;
  localparam logic [7:0] BT_T4 = 8'hCC;
  localparam logic [7:0] BT_T5 = 8'hD2;
  localparam logic [7:0] BT_T6 = 8'hE1;
  localparam logic [7:0] BT_T7 = 8'hFF;

  localparam logic [6:0] CC_IDLE  = 7'h00;
  localparam logic [6:0] CC_ERROR = 7'h1E;

  // Error block payload: control type followed by eight error codes.
  localparam logic [63:0] EBLOCK_PAYLOAD = {{8{CC_ERROR}}, BT_C};

  typedef enum logic [2:0] {BLK_C, BLK_S, BLK_D, BLK_T, BLK_E} blk_class_e;

  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_e;

  function automatic logic [7:0] bt_term(input logic [2:0] k);
    case (k)
      3'd0:    return BT_T0;
      3'd1:    return BT_T1;
      3'd2:    return BT_T2;
      3'd3:    return BT_T3;
      3'd4:    return BT_T4;
      3'd5:    return BT_T5;
      3'd6:    return BT_T6;
      default: return BT_T7;
    endcase
  endfunction

endpackage

// File: rtl/pcs_scrambler_58.sv
// Self-synchronous x^58+x^39+1 payload scrambler, bit 0 first; state advances
// only when i_en is high. Used by the encoder under PCS_SCRAMBLER_EN.
module pcs_scrambler_58 (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);

  logic [57:0] state_q;
  logic [57:0] state_d;
  logic [63:0] scr;

  // NOTE: blocking assignments here model the bit-serial recurrence; each
  // iteration must see the state updated by the previous one.
  always_comb begin
    state_d = state_q;
    scr     = '0;
    for (int i = 0; i < 64; i++) begin
      scr[i]  = i_data[i] ^ state_d[38] ^ state_d[57];
      state_d = {state_d[56:0], scr[i]};
    end
  end

  assign o_data = scr;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)     state_q <= '1;
    else if (i_en) state_q <= state_d;
  end

endmodule

// File: rtl/pcs_64b66b_encoder.sv
// 64b/66b transmit encoder: classifies XGMII words, runs the TX block-sequence
// FSM, substitutes error blocks. Define PCS_SCRAMBLER_EN to scramble payload.
module pcs_64b66b_encoder
  import pcs_64b66b_pkg::*;
#(
  parameter int          DATA_WIDTH     = 64,
  parameter int          CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter logic [7:0]  IDLE_CODE      = 8'h07,
  parameter logic [7:0]  START_CODE     = 8'hFB,
  parameter logic [7:0]  TERMINATE_CODE = 8'hFD,
  parameter logic [7:0]  ERROR_CODE     = 8'hFE,
  parameter int          ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_tx_data,
  input  logic [CTRL_WIDTH-1:0]    i_tx_ctrl,
  output logic                     o_valid,
  output logic [DATA_WIDTH+1:0]    o_block,
  output logic                     o_enc_err,
  output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

  logic [7:0]      ctl_ok;
  logic [7:0][6:0] code7;
  logic [7:0]      term_ok;
  blk_class_e      cls;
  logic [63:0]     blk_payload;
  logic            legal;
  tx_state_e       state;
  tx_state_e       state_next;
  logic [63:0]     enc_payload;
  logic [63:0]     out_payload;

  // Per-lane control character legality and its 7-bit code.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      ctl_ok[i] = i_tx_ctrl[i] && (i_tx_data[8*i +: 8] == IDLE_CODE ||
                                   i_tx_data[8*i +: 8] == ERROR_CODE);
      code7[i]  = (i_tx_data[8*i +: 8] == ERROR_CODE) ? CC_ERROR : CC_IDLE;
    end
  end

  // Terminate in lane k: control from lane k upward, idle/error after k.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      term_ok[k] = (i_tx_ctrl == (8'hFF << k)) &&
                   (i_tx_data[8*k +: 8] == TERMINATE_CODE);
      for (int j = 0; j < 8; j++)
        if (j > k) term_ok[k] = term_ok[k] & ctl_ok[j];
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cls         = BLK_E;
    blk_payload = '0;
    if (i_tx_ctrl == 8'h00) begin
      cls         = BLK_D;
      blk_payload = i_tx_data;
    end else if (i_tx_ctrl == 8'hFF && &ctl_ok) begin
      cls         = BLK_C;
      blk_payload = {code7, BT_C};
    end else if (i_tx_ctrl == 8'h01 && i_tx_data[7:0] == START_CODE) begin
      cls         = BLK_S;
      blk_payload = {i_tx_data[63:8], BT_S0};
    end else if (i_tx_ctrl == 8'h1F && &ctl_ok[3:0] &&
                 i_tx_data[39:32] == START_CODE) begin
      cls         = BLK_S;
      blk_payload = {i_tx_data[63:40], 4'b0, code7[3], code7[2], code7[1],
                     code7[0], BT_S4};
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (term_ok[k]) begin
          cls              = BLK_T;
          blk_payload[7:0] = bt_term(3'(k));
          for (int i = 0; i < 8; i++) begin
            if (i < k) blk_payload[8+8*i +: 8] = i_tx_data[8*i +: 8];
            if (i > k) blk_payload[8+7*i +: 7] = code7[i];
          end
        end
      end
    end
  end

  always_comb begin
    legal      = 1'b1;
    state_next = TX_E;
    case (state)
      TX_D: begin
        case (cls)
          BLK_D:   state_next = TX_D;
          BLK_T:   state_next = TX_T;
          default: legal      = 1'b0;
        endcase
      end
      TX_E: begin
        case (cls)
          BLK_C:        state_next = TX_C;
          BLK_S, BLK_D: state_next = TX_D;
          BLK_T:        state_next = TX_T;
          default:      legal      = 1'b0;
        endcase
      end
      default: begin
        case (cls)
          BLK_C:   state_next = TX_C;
          BLK_S:   state_next = TX_D;
          default: legal      = 1'b0;
        endcase
      end
    endcase
  end

  assign enc_payload = legal ? blk_payload : EBLOCK_PAYLOAD;

`ifdef PCS_SCRAMBLER_EN
  pcs_scrambler_58 u_scrambler (
    .clk    (clk),
    .i_rst  (i_rst),
    .i_en   (i_valid),
    .i_data (enc_payload),
    .o_data (out_payload)
  );
`else
  assign out_payload = enc_payload;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= TX_INIT;
      o_valid   <= 1'b0;
      o_block   <= '0;
      o_enc_err <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_valid   <= i_valid;
      o_enc_err <= 1'b0;
      if (i_valid) begin
        state     <= state_next;
        o_block   <= {out_payload, (legal && cls == BLK_D) ? SYNC_DATA : SYNC_CTRL};
        o_enc_err <= ~legal;
        if (!legal && !(&o_err_cnt)) o_err_cnt <= o_err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule
